// File: rtl/ocm_noise_port_arbiter.sv
// Round-robin arbiter sharing one noise-OCM port between two burst masters (m0, m1); OCM_ARB_PERF_EN adds wait counters.
// Latency: gnt in the deciding IDLE cycle, read data one cycle after each address, one IDLE cycle between bursts.
// Backpressure: requests are held until gnt; write bursts stall on wvalid=0; reads stream without gaps.
module ocm_noise_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8960,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m0_req,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [LEN_W-1:0]    m0_len,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic                m0_wvalid,
    output logic                m0_gnt,
    output logic                m0_err,
    output logic                m0_wready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rvalid,
    output logic                m0_done,
    input  logic                m1_req,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [LEN_W-1:0]    m1_len,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic                m1_wvalid,
    output logic                m1_gnt,
    output logic                m1_err,
    output logic                m1_wready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rvalid,
    output logic                m1_done,
    output logic [ADDR_W-1:0]   ocm_address,
    output logic [DATA_W/8-1:0] ocm_byteenable,
    output logic                ocm_chipselect,
    output logic                ocm_write,
    output logic [DATA_W-1:0]   ocm_writedata,
    output logic                ocm_clken,
`ifdef OCM_ARB_PERF_EN
    input  logic [DATA_W-1:0]   ocm_readdata,
    output logic [31:0]         m0_wait_cnt,
    output logic [31:0]         m1_wait_cnt
`else
    input  logic [DATA_W-1:0]   ocm_readdata
`endif
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                sel_q;      // master owning the current/last burst
    logic                last_q;     // 1: m1 won the last grant, so m0 is favoured
    logic                wr_q;
    logic                rvalid_q;
    logic                done_q;

    logic                req_any, pick, grant, addr_err;
    logic                pick_write;
    logic [ADDR_W-1:0]   pick_addr;
    logic [LEN_W-1:0]    pick_len;
    logic                sel_wvalid;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_be;
    logic                rd_issue, beat, advance, last_beat;

    assign req_any    = m0_req | m1_req;
    assign pick       = m1_req & (~m0_req | ~last_q);
    assign pick_write = pick ? m1_write : m0_write;
    assign pick_addr  = pick ? m1_addr  : m0_addr;
    assign pick_len   = pick ? m1_len   : m0_len;
    assign grant      = (state_q == S_IDLE) & req_any;
    assign addr_err   = pick_addr > LAST_ADDR;

    assign sel_wvalid = sel_q ? m1_wvalid : m0_wvalid;
    assign sel_wdata  = sel_q ? m1_wdata  : m0_wdata;
    assign sel_be     = sel_q ? m1_be     : m0_be;

    assign rd_issue  = (state_q == S_BURST) & ~wr_q;
    assign beat      = (state_q == S_BURST) & wr_q & sel_wvalid;
    assign advance   = rd_issue | beat;
    assign last_beat = advance & (cnt_q == LEN_ONE);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant && !addr_err) begin
                    state_d = S_BURST;
                    cur_d   = pick_addr;
                    cnt_d   = (pick_len == '0) ? LEN_ONE : pick_len;
                end
            end
            S_BURST: begin
                if (advance) begin
                    cur_d = (cur_q == LAST_ADDR) ? '0 : cur_q + 1'b1;
                    cnt_d = cnt_q - LEN_ONE;
                    if (last_beat)
                        state_d = wr_q ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rd_issue;
            // Reads finish with the trailing rvalid; writes and rejects finish one cycle later.
            done_q   <= (grant & addr_err) | last_beat;
            if (grant) begin
                sel_q  <= pick;
                last_q <= pick;
                wr_q   <= pick_write;
            end
        end
    end

    assign m0_gnt    = grant & ~pick;
    assign m1_gnt    = grant & pick;
    assign m0_err    = m0_gnt & addr_err;
    assign m1_err    = m1_gnt & addr_err;
    assign m0_wready = (state_q == S_BURST) & wr_q & ~sel_q;
    assign m1_wready = (state_q == S_BURST) & wr_q & sel_q;
    assign m0_rvalid = rvalid_q & ~sel_q;
    assign m1_rvalid = rvalid_q & sel_q;
    assign m0_rdata  = m0_rvalid ? ocm_readdata : '0;
    assign m1_rdata  = m1_rvalid ? ocm_readdata : '0;
    assign m0_done   = done_q & ~sel_q;
    assign m1_done   = done_q & sel_q;

    assign ocm_address    = cur_q;
    assign ocm_chipselect = advance;
    assign ocm_write      = beat;
    assign ocm_writedata  = beat ? sel_wdata : '0;
    assign ocm_byteenable = rd_issue ? '1 : (beat ? sel_be : '0);
    assign ocm_clken      = 1'b1;

`ifdef OCM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_wait_cnt <= '0;
            m1_wait_cnt <= '0;
        end else begin
            if (m0_req && !m0_gnt && (m0_wait_cnt != 32'hFFFF_FFFF))
                m0_wait_cnt <= m0_wait_cnt + 32'd1;
            if (m1_req && !m1_gnt && (m1_wait_cnt != 32'hFFFF_FFFF))
                m1_wait_cnt <= m1_wait_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ocm_noise_port_arbiter.sv
// Directed bench for ocm_noise_port_arbiter; inputs change #1 after posedge, outputs sampled on negedge.
module tb_ocm_noise_port_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;
    localparam int BE_W   = DATA_W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              m0_req, m0_write, m0_wvalid, m1_req, m1_write, m1_wvalid;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [LEN_W-1:0]  m0_len, m1_len;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [BE_W-1:0]   m0_be, m1_be;
    logic              m0_gnt, m0_err, m0_wready, m0_rvalid, m0_done;
    logic              m1_gnt, m1_err, m1_wready, m1_rvalid, m1_done;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] ocm_address;
    logic [BE_W-1:0]   ocm_byteenable;
    logic              ocm_chipselect, ocm_write, ocm_clken;
    logic [DATA_W-1:0] ocm_writedata;
    logic [DATA_W-1:0] ocm_readdata = '0;
`ifdef OCM_ARB_PERF_EN
    logic [31:0]       m0_wait_cnt, m1_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ocm_noise_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_len(m0_len),
        .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_wvalid(m0_wvalid),
        .m0_gnt(m0_gnt), .m0_err(m0_err), .m0_wready(m0_wready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_done(m0_done),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_len(m1_len),
        .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_wvalid(m1_wvalid),
        .m1_gnt(m1_gnt), .m1_err(m1_err), .m1_wready(m1_wready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_done(m1_done),
        .ocm_address(ocm_address), .ocm_byteenable(ocm_byteenable),
        .ocm_chipselect(ocm_chipselect), .ocm_write(ocm_write),
        .ocm_writedata(ocm_writedata), .ocm_clken(ocm_clken),
`ifdef OCM_ARB_PERF_EN
        .ocm_readdata(ocm_readdata),
        .m0_wait_cnt(m0_wait_cnt), .m1_wait_cnt(m1_wait_cnt)
`else
        .ocm_readdata(ocm_readdata)
`endif
    );

    function automatic logic [DATA_W-1:0] rd_pat(input logic [ADDR_W-1:0] a);
        return {32'hCAFE_0000, 18'd0, a};
    endfunction

    // OCM read model: data for the presented address appears one cycle later.
    always @(posedge clk)
        if (ocm_chipselect && !ocm_write)
            ocm_readdata <= rd_pat(ocm_address);

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_write = 0; m0_addr = '0; m0_len = '0; m0_wdata = '0; m0_be = '0; m0_wvalid = 0;
        m1_req = 0; m1_write = 0; m1_addr = '0; m1_len = '0; m1_wdata = '0; m1_be = '0; m1_wvalid = 0;
    endtask

    task automatic do_reset();
        nxt();
        clear_inputs();
        reset_n = 0;
        nxt();
        nxt();
        reset_n = 1;
    endtask

    task automatic test_reset();
        logic [9:0] flags;
        clear_inputs();
        reset_n = 0;
        smp();
        flags = {m0_gnt, m0_err, m0_wready, m0_rvalid, m0_done, m1_gnt, m1_err, m1_wready, m1_rvalid, m1_done};
        checks++; if (flags !== 10'b0) begin errors++; $display("FAIL reset_master_flags: got %b want 0", flags); end
        checks++; if ({ocm_chipselect, ocm_write} !== 2'b00) begin errors++; $display("FAIL reset_cs_wr: got %b want 00", {ocm_chipselect, ocm_write}); end
        checks++; if (ocm_address !== '0 || ocm_byteenable !== '0 || ocm_writedata !== '0) begin
            errors++; $display("FAIL reset_ocm_bus: addr %0d be %h wd %h want 0", ocm_address, ocm_byteenable, ocm_writedata); end
        checks++; if (m0_rdata !== '0 || m1_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata); end
        checks++; if (ocm_clken !== 1'b1) begin errors++; $display("FAIL reset_clken: got %b want 1", ocm_clken); end
        nxt();
        reset_n = 1;
    endtask

    task automatic test_read_burst();
        logic              exp_cs, exp_rv, exp_done;
        logic [ADDR_W-1:0] exp_addr;
        nxt();
        m0_req = 1; m0_write = 0; m0_addr = 14'd100; m0_len = 8'd4;
        smp();
        checks++; if ({m0_gnt, m0_err, m1_gnt} !== 3'b100) begin errors++; $display("FAIL rd_gnt: got gnt/err/m1gnt %b want 100", {m0_gnt, m0_err, m1_gnt}); end
        for (int i = 0; i < 6; i++) begin
            nxt();
            m0_req = 0;
            smp();
            exp_cs   = (i < 4);
            exp_addr = ADDR_W'(100 + i);
            exp_rv   = (i >= 1) && (i <= 4);
            exp_done = (i == 4);
            checks++; if ({ocm_chipselect, ocm_write} !== {exp_cs, 1'b0}) begin
                errors++; $display("FAIL rd_cs[%0d]: got cs/wr %b want %b", i, {ocm_chipselect, ocm_write}, {exp_cs, 1'b0}); end
            if (exp_cs) begin
                checks++; if (ocm_address !== exp_addr || ocm_byteenable !== 8'hFF) begin
                    errors++; $display("FAIL rd_addr[%0d]: got %0d be %h want %0d be ff", i, ocm_address, ocm_byteenable, exp_addr); end
            end
            checks++; if (m0_rvalid !== exp_rv || m1_rvalid !== 1'b0) begin
                errors++; $display("FAIL rd_rvalid[%0d]: got m0 %b m1 %b want %b 0", i, m0_rvalid, m1_rvalid, exp_rv); end
            if (exp_rv) begin
                checks++; if (m0_rdata !== rd_pat(ADDR_W'(99 + i))) begin
                    errors++; $display("FAIL rd_data[%0d]: got %h want %h", i, m0_rdata, rd_pat(ADDR_W'(99 + i))); end
            end
            checks++; if (m0_done !== exp_done || m0_gnt !== 1'b0) begin
                errors++; $display("FAIL rd_done[%0d]: got done %b gnt %b want %b 0", i, m0_done, m0_gnt, exp_done); end
        end
    endtask

    task automatic test_write_gapped();
        int wv[5]    = '{1, 0, 1, 1, 0};
        int exp_a[5] = '{8958, 0, 8959, 0, 0};
        logic exp_beat;
        nxt();
        m1_req = 1; m1_write = 1; m1_addr = 14'd8958; m1_len = 8'd3;
        m1_wvalid = 1; m1_wdata = 64'hBEEF_0000_0000_0077; m1_be = 8'h3C;
        smp();
        checks++; if ({m1_gnt, m1_err, m0_gnt} !== 3'b100) begin errors++; $display("FAIL wr_gnt: got gnt/err/m0gnt %b want 100", {m1_gnt, m1_err, m0_gnt}); end
        checks++; if (ocm_chipselect !== 1'b0 || m1_wready !== 1'b0) begin
            errors++; $display("FAIL wr_idle_quiet: got cs %b wready %b want 0 0", ocm_chipselect, m1_wready); end
        for (int i = 0; i < 5; i++) begin
            nxt();
            m1_req    = 0;
            m1_wvalid = (wv[i] != 0);
            m1_wdata  = {48'hBEEF_0000_0000, 16'(i)};
            m1_be     = 8'hF0 | 8'(i);
            smp();
            exp_beat = (wv[i] != 0) && (i < 4);
            checks++; if ({ocm_chipselect, ocm_write} !== {exp_beat, exp_beat}) begin
                errors++; $display("FAIL wr_cs[%0d]: got cs/wr %b want %b", i, {ocm_chipselect, ocm_write}, {exp_beat, exp_beat}); end
            checks++; if (m1_wready !== (i < 4) || m0_wready !== 1'b0) begin
                errors++; $display("FAIL wr_wready[%0d]: got m1 %b m0 %b want %b 0", i, m1_wready, m0_wready, (i < 4)); end
            if (exp_beat) begin
                checks++; if (ocm_address !== ADDR_W'(exp_a[i]) || ocm_writedata !== m1_wdata || ocm_byteenable !== m1_be) begin
                    errors++; $display("FAIL wr_beat[%0d]: got addr %0d wd %h be %h want %0d %h %h",
                                       i, ocm_address, ocm_writedata, ocm_byteenable, exp_a[i], m1_wdata, m1_be); end
            end
            checks++; if (m1_done !== (i == 4)) begin errors++; $display("FAIL wr_done[%0d]: got %b want %b", i, m1_done, (i == 4)); end
        end
        nxt();
        m1_wvalid = 0;
        smp();
        checks++; if (m1_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %b want 0", m1_done); end
    endtask

    task automatic test_round_robin();
        int   order[3] = '{0, 1, 0};
        int   g = 0;
        int   last_c = 0;
        logic got, who, rr0, rr1;
        rr0 = 0; rr1 = 0;
        do_reset();
        m0_req = 1; m0_write = 0; m0_addr = 14'd10; m0_len = 8'd1;
        m1_req = 1; m1_write = 0; m1_addr = 14'd20; m1_len = 8'd1;
        for (int c = 0; c < 30 && g < 3; c++) begin
            smp();
            got = m0_gnt | m1_gnt;
            who = m1_gnt;
            if (m0_gnt && m1_gnt) begin checks++; errors++; $display("FAIL rr_both: got both gnt at cycle %0d want one", c); end
            if (got) begin
                checks++; if (int'(who) != order[g]) begin errors++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", g, who, order[g]); end
                if (g > 0) begin
                    checks++; if (c - last_c != 3) begin errors++; $display("FAIL rr_gap[%0d]: got %0d cycles want 3", g, c - last_c); end
                end
                last_c = c;
                g++;
            end
            nxt();
            if (rr0) begin m0_req = 1; rr0 = 0; end
            if (rr1) begin m1_req = 1; rr1 = 0; end
            if (got) begin
                if (who) begin m1_req = 0; rr1 = 1; end
                else     begin m0_req = 0; rr0 = 1; end
            end
        end
        checks++; if (g != 3) begin errors++; $display("FAIL rr_count: got %0d grants want 3", g); end
        m0_req = 0;
        m1_req = 0;
        for (int i = 0; i < 4; i++) begin
            smp();
            checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                errors++; $display("FAIL rr_withdraw[%0d]: got gnt %b%b want 00", i, m0_gnt, m1_gnt); end
            nxt();
        end
    endtask

    task automatic test_addr_error();
        smp();
        m0_req = 1; m0_write = 0; m0_addr = 14'd9000; m0_len = 8'd5;
        smp();
        checks++; if ({m0_gnt, m0_err, ocm_chipselect} !== 3'b110) begin
            errors++; $display("FAIL err_gnt: got gnt/err/cs %b want 110", {m0_gnt, m0_err, ocm_chipselect}); end
        nxt();
        m0_req = 0;
        smp();
        checks++; if ({m0_done, m0_gnt, m0_err, ocm_chipselect, m0_rvalid} !== 5'b10000) begin
            errors++; $display("FAIL err_done: got done/gnt/err/cs/rv %b want 10000", {m0_done, m0_gnt, m0_err, ocm_chipselect, m0_rvalid}); end
        nxt();
        smp();
        checks++; if ({m0_done, ocm_chipselect} !== 2'b00) begin
            errors++; $display("FAIL err_after: got done/cs %b want 00", {m0_done, ocm_chipselect}); end
    endtask

    task automatic test_len_zero_last_addr();
        nxt();
        m1_req = 1; m1_write = 0; m1_addr = 14'd8959; m1_len = 8'd0;
        smp();
        checks++; if ({m1_gnt, m1_err} !== 2'b10) begin errors++; $display("FAIL l0_gnt: got gnt/err %b want 10", {m1_gnt, m1_err}); end
        nxt();
        m1_req = 0;
        smp();
        checks++; if (ocm_chipselect !== 1'b1 || ocm_address !== 14'd8959 || m1_rvalid !== 1'b0) begin
            errors++; $display("FAIL l0_addr: got cs %b addr %0d rv %b want 1 8959 0", ocm_chipselect, ocm_address, m1_rvalid); end
        nxt();
        smp();
        checks++; if ({ocm_chipselect, m1_rvalid, m1_done} !== 3'b011 || m1_rdata !== rd_pat(14'd8959)) begin
            errors++; $display("FAIL l0_data: got cs/rv/done %b data %h want 011 %h", {ocm_chipselect, m1_rvalid, m1_done}, m1_rdata, rd_pat(14'd8959)); end
        nxt();
        smp();
        checks++; if ({m1_rvalid, m1_done} !== 2'b00) begin errors++; $display("FAIL l0_end: got rv/done %b want 00", {m1_rvalid, m1_done}); end
    endtask

    task automatic test_reset_mid_burst();
        nxt();
        m0_req = 1; m0_write = 0; m0_addr = 14'd200; m0_len = 8'd8;
        smp();
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b want 1", m0_gnt); end
        for (int i = 0; i < 3; i++) begin
            nxt();
            m0_req = 0;
            smp();
        end
        checks++; if (ocm_chipselect !== 1'b1 || ocm_address !== 14'd202) begin
            errors++; $display("FAIL rst_pre: got cs %b addr %0d want 1 202", ocm_chipselect, ocm_address); end
        nxt();
        reset_n = 0;
        #1;
        checks++; if (ocm_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs_drop: got %b want 0", ocm_chipselect); end
        smp();
        checks++; if ({m0_done, m0_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_quiet: got done/rv %b want 00", {m0_done, m0_rvalid}); end
        nxt();
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            checks++; if ({m0_done, ocm_chipselect} !== 2'b00) begin
                errors++; $display("FAIL rst_no_done[%0d]: got done/cs %b want 00", i, {m0_done, ocm_chipselect}); end
            nxt();
        end
        m0_req = 1; m0_addr = 14'd30; m0_len = 8'd1;
        m1_req = 1; m1_write = 0; m1_addr = 14'd40; m1_len = 8'd1;
        smp();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rst_priority: got m0/m1 gnt %b want 10", {m0_gnt, m1_gnt}); end
        nxt();
        m0_req = 0;
        m1_req = 0;
        for (int i = 0; i < 3; i++) nxt();
    endtask

`ifdef OCM_ARB_PERF_EN
    task automatic test_perf_wait();
        logic found = 0;
        do_reset();
        m0_req = 1; m0_write = 0; m0_addr = 14'd0; m0_len = 8'd10;
        m1_req = 1; m1_write = 0; m1_addr = 14'd5; m1_len = 8'd1;
        smp();
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL perf_m0_gnt: got %b want 1", m0_gnt); end
        nxt();
        m0_req = 0;
        for (int c = 0; c < 30; c++) begin
            smp();
            if (m1_gnt) begin found = 1; break; end
            nxt();
        end
        checks++; if (!found) begin errors++; $display("FAIL perf_m1_gnt: got none want gnt within 30 cycles"); end
        checks++; if (m1_wait_cnt !== 32'd12 || m0_wait_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_cnt: got m0 %0d m1 %0d want 0 12", m0_wait_cnt, m1_wait_cnt); end
        nxt();
        m1_req = 0;
        smp();
        checks++; if (m1_wait_cnt !== 32'd12) begin errors++; $display("FAIL perf_hold: got %0d want 12", m1_wait_cnt); end
        for (int i = 0; i < 3; i++) nxt();
    endtask
`endif

    initial begin
        test_reset();
        test_read_burst();
        test_write_gapped();
        test_round_robin();
        test_addr_error();
        test_len_zero_last_addr();
        test_reset_mid_burst();
`ifdef OCM_ARB_PERF_EN
        test_perf_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
